// File: rtl/writeback_stage.sv
// Writeback stage: holds one M-stage instruction, waits for late load data, drives the
// register-file write port and the forwarding path. WB_INSTRET_EN builds the 64-bit commit counter.
module writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  validM,
  output logic                  readyW,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [REG_AW-1:0]     RdM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic [DATA_WIDTH-1:0] ReadDataM,
  input  logic                  ReadDataValidM,
  output logic                  rf_we,
  output logic [REG_AW-1:0]     rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_AW-1:0]     fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  stall_load,
  output logic [63:0]           instret
);

  typedef enum logic [1:0] {EMPTY, VALID, WAIT_LOAD} state_t;

  state_t                  state_reg, state_next;
  logic                    capture;
  logic                    rdata_load;
  logic                    regwrite_reg;
  logic [1:0]              src_reg;
  logic [REG_AW-1:0]       rd_reg;
  logic [DATA_WIDTH-1:0]   alu_reg, pc4_reg, rdata_reg;

  assign readyW  = (state_reg != WAIT_LOAD);
  assign capture = validM && readyW;

  always_comb begin
    state_next = state_reg;
    rdata_load = 1'b0;
    case (state_reg)
      EMPTY, VALID: begin
        if (capture) begin
          if (ResultSrcM == 2'b01 && !ReadDataValidM) begin
            state_next = WAIT_LOAD;
          end else begin
            state_next = VALID;
            rdata_load = 1'b1;
          end
        end else begin
          state_next = EMPTY;
        end
      end
      WAIT_LOAD: begin
        if (ReadDataValidM) begin
          state_next = VALID;
          rdata_load = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Held fields clear on reset so every output decodes to zero, including a discarded pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      regwrite_reg <= 1'b0;
      src_reg      <= 2'b00;
      rd_reg       <= '0;
      alu_reg      <= '0;
      pc4_reg      <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        regwrite_reg <= RegWriteM;
        src_reg      <= ResultSrcM;
        rd_reg       <= RdM;
        alu_reg      <= ALUResultM;
        pc4_reg      <= PCPlus4M;
      end
      if (rdata_load) begin
        rdata_reg <= ReadDataM;
      end
    end
  end

  always_comb begin
    rf_wdata = '0;
    case (src_reg)
      2'b00:   rf_wdata = alu_reg;
      2'b01:   rf_wdata = rdata_reg;
      2'b10:   rf_wdata = pc4_reg;
      default: rf_wdata = '0;
    endcase
  end

  assign rf_we      = (state_reg == VALID) && regwrite_reg && (rd_reg != '0) && (src_reg != 2'b11);
  assign rf_waddr   = rd_reg;
  assign fwd_valid  = rf_we;
  assign fwd_rd     = rd_reg;
  assign fwd_data   = rf_wdata;
  assign stall_load = (state_reg == WAIT_LOAD);

`ifdef WB_INSTRET_EN
  logic [63:0] instret_reg;

  // Every cycle in VALID is one commit, whether or not it writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_reg <= 64'd0;
    end else if (state_reg == VALID) begin
      instret_reg <= instret_reg + 64'd1;
    end
  end

  assign instret = instret_reg;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, ALU commit, delayed load, back-to-back,
// suppressed writes, reset during a pending load and the commit counter.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        validM = 1'b0;
  logic        readyW;
  logic        RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [4:0]  RdM = '0;
  logic [31:0] ALUResultM = '0, PCPlus4M = '0, ReadDataM = '0;
  logic        ReadDataValidM = 1'b0;
  logic        rf_we, fwd_valid, stall_load;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, fwd_data;
  logic [63:0] instret;

  int checks = 0;
  int fails  = 0;

`ifdef WB_INSTRET_EN
  localparam bit INSTRET_ON = 1'b1;
`else
  localparam bit INSTRET_ON = 1'b0;
`endif

  writeback_stage #(.DATA_WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .validM(validM), .readyW(readyW),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
    .ReadDataValidM(ReadDataValidM), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .stall_load(stall_load), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] src, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] rdat,
                       input logic rdv);
    validM = v; RegWriteM = we; ResultSrcM = src; RdM = rd;
    ALUResultM = alu; PCPlus4M = pc4; ReadDataM = rdat; ReadDataValidM = rdv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (readyW !== 1'b1) begin fails++; $display("FAIL reset_readyW got %0b want 1", readyW); end
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    checks++; if (fwd_valid !== 1'b0) begin fails++; $display("FAIL reset_fwd_valid got %0b want 0", fwd_valid); end
    checks++; if (stall_load !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b want 0", stall_load); end
    checks++; if (rf_waddr !== 5'd0 || fwd_rd !== 5'd0) begin fails++; $display("FAIL reset_addr got %0d/%0d want 0/0", rf_waddr, fwd_rd); end
    checks++; if (rf_wdata !== 32'd0 || fwd_data !== 32'd0) begin fails++; $display("FAIL reset_data got %h/%h want 0/0", rf_wdata, fwd_data); end
    checks++; if (instret !== 64'd0) begin fails++; $display("FAIL reset_instret got %0d want 0", instret); end
    rst_n = 1'b1;
    tick();
    $display("reset: outputs idle");
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 2'b00, 5'd5, 32'h1234, 32'h99, 32'h77, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (rf_we !== 1'b1 || fwd_valid !== 1'b1) begin fails++; $display("FAIL alu_we got %0b/%0b want 1/1", rf_we, fwd_valid); end
    checks++; if (rf_waddr !== 5'd5 || fwd_rd !== 5'd5) begin fails++; $display("FAIL alu_addr got %0d/%0d want 5/5", rf_waddr, fwd_rd); end
    checks++; if (rf_wdata !== 32'h1234 || fwd_data !== 32'h1234) begin fails++; $display("FAIL alu_data got %h/%h want 1234", rf_wdata, fwd_data); end
    tick();
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL alu_idle_we got %0b want 0", rf_we); end
    $display("alu: x5 <- 0x1234");
  endtask

  task automatic test_delayed_load();
    drive(1'b1, 1'b1, 2'b01, 5'd7, 32'h5555, 32'h4, 32'h0, 1'b0);
    tick();
    // Next instruction waits at the boundary while the load is outstanding.
    drive(1'b1, 1'b1, 2'b00, 5'd9, 32'h99, 32'h8, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall_load !== 1'b1 || readyW !== 1'b0) begin fails++; $display("FAIL load_wait%0d stall/ready got %0b/%0b want 1/0", i, stall_load, readyW); end
      checks++; if (rf_we !== 1'b0 || fwd_rd !== 5'd7) begin fails++; $display("FAIL load_wait%0d we/fwd_rd got %0b/%0d want 0/7", i, rf_we, fwd_rd); end
      if (i == 2) begin ReadDataM = 32'hDEADBEEF; ReadDataValidM = 1'b1; end
      tick();
    end
    ReadDataValidM = 1'b0; ReadDataM = 32'h0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL load_commit got we=%0b x%0d=%h want 1 x7=deadbeef", rf_we, rf_waddr, rf_wdata); end
    checks++; if (readyW !== 1'b1 || stall_load !== 1'b0) begin fails++; $display("FAIL load_commit_ready got %0b/%0b want 1/0", readyW, stall_load); end
    tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin fails++; $display("FAIL load_next got we=%0b x%0d=%h want 1 x9=99", rf_we, rf_waddr, rf_wdata); end
    tick();
    $display("delayed load: x7 <- 0xdeadbeef, then x9 <- 0x99");
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 2'b00, 5'd1, 32'h1, 32'h204, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'b10, 5'd2, 32'hBAD, 32'h104, 32'h0, 1'b0);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h1 || readyW !== 1'b1) begin fails++; $display("FAIL b2b_1 got we=%0b x%0d=%h rdy=%0b want 1 x1=1 1", rf_we, rf_waddr, rf_wdata, readyW); end
    tick();
    drive(1'b1, 1'b1, 2'b01, 5'd3, 32'hBAD, 32'h108, 32'hAA, 1'b1);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h104 || readyW !== 1'b1) begin fails++; $display("FAIL b2b_2 got we=%0b x%0d=%h rdy=%0b want 1 x2=104 1", rf_we, rf_waddr, rf_wdata, readyW); end
    tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || fwd_data !== 32'hAA || readyW !== 1'b1) begin fails++; $display("FAIL b2b_3 got we=%0b x%0d=%h rdy=%0b want 1 x3=aa 1", rf_we, rf_waddr, fwd_data, readyW); end
    tick();
    $display("back-to-back: x1, x2, x3 committed");
  endtask

  task automatic test_no_write();
    drive(1'b1, 1'b1, 2'b00, 5'd0, 32'h55, 32'h0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'b11, 5'd4, 32'h66, 32'h70, 32'h80, 1'b1);
    checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin fails++; $display("FAIL x0_write got %0b/%0b want 0/0", rf_we, fwd_valid); end
    tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin fails++; $display("FAIL src11_write got %0b/%0b want 0/0", rf_we, fwd_valid); end
    checks++; if (rf_wdata !== 32'h0 || rf_waddr !== 5'd4) begin fails++; $display("FAIL src11_data got x%0d=%h want x4=0", rf_waddr, rf_wdata); end
    tick();
    // 1 + 2 + 3 + 2 commits since reset.
    checks++; if (instret !== (INSTRET_ON ? 64'd8 : 64'd0)) begin fails++; $display("FAIL instret_8 got %0d want %0d", instret, INSTRET_ON ? 8 : 0); end
    $display("suppressed writes: x0 and encoding 11");
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, 1'b1, 2'b01, 5'd12, 32'h12, 32'h0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (stall_load !== 1'b1) begin fails++; $display("FAIL rst_wait_pre got %0b want 1", stall_load); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stall_load !== 1'b0 || readyW !== 1'b1 || fwd_rd !== 5'd0 || instret !== 64'd0) begin fails++; $display("FAIL rst_wait_async got stall=%0b rdy=%0b rd=%0d ir=%0d want 0 1 0 0", stall_load, readyW, fwd_rd, instret); end
    ReadDataM = 32'h1111; ReadDataValidM = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we !== 1'b0 || stall_load !== 1'b0) begin fails++; $display("FAIL rst_wait_after%0d got we=%0b stall=%0b want 0 0", i, rf_we, stall_load); end
    end
    ReadDataValidM = 1'b0;
    $display("reset during pending load: load discarded");
  endtask

  task automatic test_instret();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 2'b00, 5'(i + 1), 32'(i * 3), 32'h0, 32'h0, 1'b0);
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i + 1) || rf_wdata !== 32'(i * 3)) begin fails++; $display("FAIL seq%0d got we=%0b x%0d=%h want 1 x%0d=%h", i, rf_we, rf_waddr, rf_wdata, i + 1, i * 3); end
    end
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (instret !== (INSTRET_ON ? 64'd10 : 64'd0)) begin fails++; $display("FAIL instret_10 got %0d want %0d", instret, INSTRET_ON ? 10 : 0); end
    $display("instret: 10 commits");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_delayed_load();
    test_back_to_back();
    test_no_write();
    test_reset_mid_wait();
    test_instret();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
